// File: rtl/pkt_decoder_fsm_if.sv
// Packet decoder bus bundle: valid/ready beat ingress, valid/ready descriptor
// egress and the running packet/error counters.
interface pkt_decoder_fsm_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_onehot;
  logic [LEN_W-1:0]  out_len;
  logic [DATA_W-1:0] out_sum;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  err_cnt;

  // Decoder side of the bundle.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_onehot, out_len, out_sum, pkt_cnt, err_cnt
  );

  // Ingress/dispatch side of the bundle.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_onehot, out_len, out_sum, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/pkt_decoder_fsm.sv
// Multi-beat packet decoder. Takes a header beat (opcode + length) followed by
// `len` payload beats and produces one descriptor per packet: one-hot opcode
// class, length and payload checksum. Malformed headers still consume their
// payload so the stream stays aligned on header boundaries.
module pkt_decoder_fsm #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 4,
  parameter int LEN_W   = 4,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  pkt_decoder_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DROP,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [OP_W-1:0]  OP_LAST   = OP_W'(3);

  state_t            r_state, w_stateNext;
  logic [4:0]        r_onehot, w_onehotNext;
  logic [LEN_W-1:0]  r_len, w_lenNext;
  logic [LEN_W-1:0]  r_beatCnt, w_beatCntNext;
  logic [DATA_W-1:0] r_sum, w_sumNext;
  logic [CNT_W-1:0]  r_pktCnt, w_pktCntNext;
  logic [CNT_W-1:0]  r_errCnt, w_errCntNext;

  logic [OP_W-1:0]   w_op;
  logic [LEN_W-1:0]  w_hdrLen;
  logic              w_malformed;
  logic [4:0]        w_hdrOnehot;
  logic              w_inFire;
  logic              w_outFire;

  assign w_op     = bus.in_data[OP_W-1:0];
  assign w_hdrLen = bus.in_data[OP_W+LEN_W-1:OP_W];

  // Handshake flags come from state only; reset holds ingress closed.
  assign bus.in_ready  = rst_n && (r_state != DONE);
  assign bus.out_valid = (r_state == DONE);
  assign w_inFire      = bus.in_valid && bus.in_ready;
  assign w_outFire     = bus.out_valid && bus.out_ready;

  assign bus.out_onehot = r_onehot;
  assign bus.out_len    = r_len;
  assign bus.out_sum    = r_sum;
  assign bus.pkt_cnt    = r_pktCnt;
  assign bus.err_cnt    = r_errCnt;

  // Classify the beat as if it were a header; only used in IDLE.
  always_comb begin
    w_malformed = 1'b1;
    w_hdrOnehot = 5'b10000;
    if ((w_op <= OP_LAST) && (w_hdrLen <= MAX_LEN_L)) begin
      w_malformed = 1'b0;
      w_hdrOnehot = 5'b00001 << w_op;
    end
  end

  // Next-state and datapath updates for header, payload, drop and hand-off.
  always_comb begin
    w_stateNext   = r_state;
    w_onehotNext  = r_onehot;
    w_lenNext     = r_len;
    w_beatCntNext = r_beatCnt;
    w_sumNext     = r_sum;
    w_pktCntNext  = r_pktCnt;
    w_errCntNext  = r_errCnt;
    case (r_state)
      IDLE: begin
        if (w_inFire) begin
          w_lenNext     = w_hdrLen;
          w_sumNext     = '0;
          w_onehotNext  = w_hdrOnehot;
          w_beatCntNext = w_hdrLen;
          if (w_hdrLen == '0) begin
            w_stateNext = DONE;
          end else if (w_malformed) begin
            w_stateNext = DROP;
          end else begin
            w_stateNext = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (w_inFire) begin
          w_sumNext     = r_sum + bus.in_data;
          w_beatCntNext = r_beatCnt - LEN_W'(1);
          if (r_beatCnt == LEN_W'(1)) begin
            w_stateNext = DONE;
          end
        end
      end
      DROP: begin
        if (w_inFire) begin
          w_beatCntNext = r_beatCnt - LEN_W'(1);
          if (r_beatCnt == LEN_W'(1)) begin
            w_stateNext = DONE;
          end
        end
      end
      DONE: begin
        if (w_outFire) begin
          w_pktCntNext = r_pktCnt + CNT_W'(1);
          if (r_onehot[4] && (r_errCnt != '1)) begin
            w_errCntNext = r_errCnt + CNT_W'(1);
          end
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_onehot  <= '0;
      r_len     <= '0;
      r_beatCnt <= '0;
      r_sum     <= '0;
      r_pktCnt  <= '0;
      r_errCnt  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_onehot  <= w_onehotNext;
      r_len     <= w_lenNext;
      r_beatCnt <= w_beatCntNext;
      r_sum     <= w_sumNext;
      r_pktCnt  <= w_pktCntNext;
      r_errCnt  <= w_errCntNext;
    end
  end

endmodule

// File: tb/tb_pkt_decoder_fsm.sv
// Testbench for pkt_decoder_fsm: a directed vector table, hand-written corner
// sequences and a randomized packet stream, all checked every cycle against a
// packet-level reference model.
module tb_pkt_decoder_fsm;

  logic clk;
  logic rst_n;

  pkt_decoder_fsm_if #(.DATA_W(16), .LEN_W(4), .CNT_W(8)) bus ();

  pkt_decoder_fsm #(
    .DATA_W(16), .OP_W(4), .LEN_W(4), .MAX_LEN(8), .CNT_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a stream parser working on whole packets.
  bit          mPending;
  bit          mInPacket;
  bit          mDrop;
  int          mBeatsLeft;
  logic [4:0]  mOnehot;
  int          mLen;
  logic [15:0] mSum;
  int          mPkt;
  int          mErr;

  typedef struct {
    bit          rstN;
    bit          inValid;
    logic [15:0] inData;
    bit          outReady;
    bit          expReady;
    bit          expValid;
    logic [4:0]  expOnehot;
    int          expLen;
    logic [15:0] expSum;
    int          expPkt;
    int          expErr;
  } vec_t;

  vec_t tbl [14];

  task automatic modelReset();
    mPending   = 1'b0;
    mInPacket  = 1'b0;
    mDrop      = 1'b0;
    mBeatsLeft = 0;
    mOnehot    = 5'b0;
    mLen       = 0;
    mSum       = 16'h0;
    mPkt       = 0;
    mErr       = 0;
  endtask

  task automatic modelBeat(input logic [15:0] data);
    int op;
    int len;
    bit bad;
    if (!mInPacket) begin
      op   = int'(data[3:0]);
      len  = int'(data[7:4]);
      bad  = (op > 3) || (len > 8);
      mLen = len;
      mSum = 16'h0;
      mOnehot = bad ? 5'b10000 : 5'(1 << op);
      if (len == 0) begin
        mPending = 1'b1;
      end else begin
        mInPacket  = 1'b1;
        mBeatsLeft = len;
        mDrop      = bad;
      end
    end else begin
      if (!mDrop) mSum = mSum + data;
      mBeatsLeft--;
      if (mBeatsLeft == 0) begin
        mInPacket = 1'b0;
        mPending  = 1'b1;
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("in_ready",   32'(bus.in_ready),   32'(rst_n && !mPending));
    checkVal("out_valid",  32'(bus.out_valid),  32'(mPending));
    checkVal("out_onehot", 32'(bus.out_onehot), 32'(mOnehot));
    checkVal("out_len",    32'(bus.out_len),    32'(mLen));
    checkVal("out_sum",    32'(bus.out_sum),    32'(mSum));
    checkVal("pkt_cnt",    32'(bus.pkt_cnt),    32'(mPkt));
    checkVal("err_cnt",    32'(bus.err_cnt),    32'(mErr));
  endtask

  // Drive one cycle at the falling edge, advance the model, check next falling edge.
  task automatic applyStimulus(input bit rstN, input bit inValid, input logic [15:0] data,
                               input bit outReady, output bit inFired);
    rst_n         = rstN;
    bus.in_valid  = inValid;
    bus.in_data   = data;
    bus.out_ready = outReady;
    inFired = 1'b0;
    if (!rstN) begin
      modelReset();
    end else if (mPending) begin
      if (outReady) begin
        mPkt = (mPkt + 1) % 256;
        if (mOnehot[4] && (mErr < 255)) mErr++;
        mPending = 1'b0;
      end
    end else if (inValid) begin
      inFired = 1'b1;
      modelBeat(data);
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic sendBeat(input logic [15:0] data, input bit rnd);
    bit fired;
    int n;
    fired = 1'b0;
    n = 0;
    while (!fired) begin
      if (rnd && ($urandom_range(3) == 0))
        applyStimulus(1'b1, 1'b0, 16'($urandom), 1'($urandom_range(1)), fired);
      else
        applyStimulus(1'b1, 1'b1, data, rnd ? 1'($urandom_range(1)) : 1'b1, fired);
      n++;
      if (!fired && n > 200) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL beat_timeout: got no transfer in %0d cycles, expected one", n);
        break;
      end
    end
  endtask

  task automatic sendPacket(input logic [3:0] op, input logic [3:0] len, input bit rnd);
    sendBeat({8'h00, len, op}, rnd);
    for (int i = 0; i < int'(len); i++) sendBeat(16'($urandom), rnd);
  endtask

  task automatic idle(input int n, input bit outReady);
    bit f;
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'h0, outReady, f);
  endtask

  // Bounded overall run time so the bench can never hang.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    bit f;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.out_ready = 1'b0;
    modelReset();

    //         rst  vld  data      ordy  rdy  val  onehot    len sum       pkt err
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b00000, 0, 16'h0000, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 16'h0031, 1'b1, 1'b0, 1'b0, 5'b00000, 0, 16'h0000, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5'b00000, 0, 16'h0000, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 16'h0031, 1'b1, 1'b1, 1'b0, 5'b00010, 3, 16'h0000, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, 1'b0, 5'b00010, 3, 16'h0010, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b0, 5'b00010, 3, 16'h0030, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 16'hFFF0, 1'b1, 1'b0, 1'b1, 5'b00010, 3, 16'h0020, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 5'b00010, 3, 16'h0020, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 5'b00100, 0, 16'h0000, 1, 0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b00100, 0, 16'h0000, 1, 0};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b00100, 0, 16'h0000, 1, 0};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b00100, 0, 16'h0000, 1, 0};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 5'b00100, 0, 16'h0000, 2, 0};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5'b00100, 0, 16'h0000, 2, 0};

    @(negedge clk);
    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].rstN, tbl[i].inValid, tbl[i].inData, tbl[i].outReady, f);
      checkVal("tbl_in_ready",   32'(bus.in_ready),   32'(tbl[i].expReady));
      checkVal("tbl_out_valid",  32'(bus.out_valid),  32'(tbl[i].expValid));
      checkVal("tbl_out_onehot", 32'(bus.out_onehot), 32'(tbl[i].expOnehot));
      checkVal("tbl_out_len",    32'(bus.out_len),    32'(tbl[i].expLen));
      checkVal("tbl_out_sum",    32'(bus.out_sum),    32'(tbl[i].expSum));
      checkVal("tbl_pkt_cnt",    32'(bus.pkt_cnt),    32'(tbl[i].expPkt));
      checkVal("tbl_err_cnt",    32'(bus.err_cnt),    32'(tbl[i].expErr));
    end

    $display("[TB] malformed headers: bad opcode, then oversized length");
    sendPacket(4'd9, 4'd2, 1'b0);
    checkVal("bad_op_valid",  32'(bus.out_valid),  32'd1);
    checkVal("bad_op_onehot", 32'(bus.out_onehot), 32'h10);
    checkVal("bad_op_len",    32'(bus.out_len),    32'd2);
    sendPacket(4'd0, 4'd12, 1'b0);
    checkVal("big_len_valid",  32'(bus.out_valid),  32'd1);
    checkVal("big_len_onehot", 32'(bus.out_onehot), 32'h10);
    checkVal("big_len_len",    32'(bus.out_len),    32'd12);
    checkVal("big_len_sum",    32'(bus.out_sum),    32'd0);
    idle(1, 1'b1);
    checkVal("two_err_cnt", 32'(bus.err_cnt), 32'd2);
    checkVal("four_pkt_cnt", 32'(bus.pkt_cnt), 32'd4);

    $display("[TB] reset in the middle of a packet");
    sendBeat(16'h0043, 1'b0);
    sendBeat(16'h1111, 1'b0);
    sendBeat(16'h2222, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h3333, 1'b1, f);
    checkVal("rst_in_ready", 32'(bus.in_ready),   32'd0);
    checkVal("rst_onehot",   32'(bus.out_onehot), 32'd0);
    checkVal("rst_len",      32'(bus.out_len),    32'd0);
    checkVal("rst_sum",      32'(bus.out_sum),    32'd0);
    checkVal("rst_pkt_cnt",  32'(bus.pkt_cnt),    32'd0);
    checkVal("rst_err_cnt",  32'(bus.err_cnt),    32'd0);
    sendBeat(16'h0010, 1'b0);
    sendBeat(16'h0005, 1'b0);
    checkVal("post_rst_valid",  32'(bus.out_valid),  32'd1);
    checkVal("post_rst_onehot", 32'(bus.out_onehot), 32'h01);
    checkVal("post_rst_sum",    32'(bus.out_sum),    32'h0005);
    idle(1, 1'b1);

    $display("[TB] 256 back-to-back invalid packets");
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, f);
    for (int i = 0; i < 256; i++) sendBeat(16'h000F, 1'b0);
    idle(1, 1'b1);
    checkVal("sat_err_cnt",  32'(bus.err_cnt), 32'hFF);
    checkVal("wrap_pkt_cnt", 32'(bus.pkt_cnt), 32'h00);

    $display("[TB] randomized packet stream");
    for (int p = 0; p < 300; p++) begin
      if ($urandom_range(29) == 0) applyStimulus(1'b0, 1'($urandom_range(1)), 16'($urandom), 1'b1, f);
      sendPacket(4'($urandom_range(15)),
                 ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(8)),
                 1'b1);
    end
    idle(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pkt_decoder_fsm.md
Name: pkt_decoder_fsm

Overview:
- Parametrised, multi-beat successor to the single-cycle opcode decoder.
- Accepts a stream of packets over a valid/ready input. Each packet is one header beat (opcode + length) followed by `len` payload beats.
- Emits one decoded descriptor per packet: one-hot opcode class (LOAD/STORE/JUMP/ALU_OP/INVALID), length and payload checksum, on a valid/ready output.
- Keeps running packet and error counters. Sits between the packet ingress and the execution-unit dispatch.

Parameters:
- DATA_W, 16: width of input beat and of the checksum.
- OP_W, 4: opcode field width, header bits [OP_W-1:0].
- LEN_W, 4: length field width, header bits [OP_W+LEN_W-1:OP_W].
- MAX_LEN, 8: largest legal payload length in beats; must be ≤ 2^LEN_W-1.
- CNT_W, 8: width of pkt_cnt and err_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  decoder can accept a beat.
- in_data  in  DATA_W  header or payload beat.
- out_valid  out  1  descriptor valid.
- out_ready  in  1  downstream accepts descriptor.
- out_onehot  out  5  bit0 LOAD, bit1 STORE, bit2 JUMP, bit3 ALU_OP, bit4 INVALID.
- out_len  out  LEN_W  header length field as received.
- out_sum  out  DATA_W  sum of payload beats, mod 2^DATA_W.
- pkt_cnt  out  CNT_W  descriptors handed off; wraps.
- err_cnt  out  CNT_W  INVALID descriptors handed off; saturates at all-ones.

Behaviour:
- Reset: rst_n sampled low at posedge → state IDLE. All of the following are 0: out_valid, out_onehot, out_len, out_sum, pkt_cnt, err_cnt, beat counter. in_ready is forced 0 while rst_n is low.
- Reset mid-packet or while a descriptor is pending discards everything; the next beat after release is treated as a header.
- Handshake: a beat transfers when in_valid && in_ready. A descriptor transfers when out_valid && out_ready.
- in_ready and out_valid are decoded from state only; they never depend combinationally on in_valid or out_ready.
- in_data must be held stable while in_valid=1 and in_ready=0. Payload is never stalled by the decoder except in DONE.
- Opcode map: 0 LOAD, 1 STORE, 2 JUMP, 3 ALU_OP, all other values INVALID.
- Header is malformed if the opcode is INVALID or len > MAX_LEN.
- IDLE (in_ready=1, out_valid=0), on header transfer:
  - Latch out_len = len and out_sum = 0.
  - Latch out_onehot = class bit; bit4 only if malformed.
  - Load beat counter with len.
  - If len == 0 → DONE.
  - Else if malformed → DROP.
  - Else → PAYLOAD.
- PAYLOAD (in_ready=1): each transfer adds in_data to out_sum and decrements the counter. On the transfer with counter == 1 → DONE.
- DROP (in_ready=1): consumes len beats, out_sum unchanged. On the last beat → DONE. A malformed header with len > MAX_LEN still drops exactly len beats.
- DONE (in_ready=0, out_valid=1): outputs held stable until out_ready.
  - On descriptor transfer: pkt_cnt += 1 (wraps); err_cnt += 1 if out_onehot[4], saturating at 2^CNT_W-1.
  - Then → IDLE. out_valid drops next cycle; out_onehot, out_len and out_sum retain their values.
- Latency: out_valid rises the cycle after the last beat transfer (the header beat when len = 0).
- Throughput: packet of len beats takes at least len+2 cycles (header, payload, one DONE cycle).
- Counters update only on the descriptor transfer edge, never on the header edge.

Test Plan:
- Reset release with in_valid=0 → in_ready=1 cycle after rst_n=1; out_valid=0; pkt_cnt=0; err_cnt=0.
- Header op=1 len=3, payloads 0x0010, 0x0020, 0xFFF0, out_ready=1 → next cycle out_valid=1, out_onehot=00010, out_len=3, out_sum=0x0020 (wrap). pkt_cnt=1 after transfer.
- Header op=2 len=0, out_ready held 0 for 4 cycles → out_valid=1, onehot 00100, out_sum=0, in_ready=0 for those 4 cycles. Descriptor transfers on the cycle out_ready=1.
- Header op=9 len=2 plus 2 beats, then header op=0 len=12 (>MAX_LEN) plus 12 beats → two descriptors with onehot 10000, out_len=2 then 12. err_cnt=2; the beat after each packet is decoded as a header.
- rst_n=0 for 1 cycle after header op=3 len=4 and 2 payload beats → all outputs 0. Next header op=0 len=1, beat 0x0005 → onehot 00001, out_sum=0x0005.
- 256 back-to-back INVALID packets (len=0) with out_ready=1 → err_cnt stays 0xFF, pkt_cnt wraps to 0x00.
